// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: field layout, opcodes,
// FSM states and the ID/EX register layout.
package decode_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int FA_MSB   = 11;
    localparam int FA_LSB   = 8;
    localparam int FB_MSB   = 7;
    localparam int FB_LSB   = 4;
    localparam int FC_MSB   = 3;
    localparam int FC_LSB   = 0;
    localparam int JOFF_MSB = 11;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ALU  = 4'h0;
    localparam opcode_t OP_BEQ  = 4'h4;
    localparam opcode_t OP_BNE  = 4'h5;
    localparam opcode_t OP_LW   = 4'h8;
    localparam opcode_t OP_SW   = 4'hB;
    localparam opcode_t OP_JMP  = 4'hC;
    localparam opcode_t OP_HALT = 4'hF;

    // Opcode 0x1 is unassigned, so this word decodes as a plain NOP.
    localparam logic [DATA_W-1:0] NOP_INST = 16'h1000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [3:0]        op;
        logic [3:0]        func;
        logic [3:0]        rd;
        logic [DATA_W-1:0] a_data;
        logic [DATA_W-1:0] b_data;
        logic [DATA_W-1:0] imm;
    } idex_t;

    function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
        return {{(DATA_W-4){v[3]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return {{(DATA_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 16x16 register file for ID: two asynchronous read ports with write-through
// bypass, one synchronous write port, R0 hardwired to zero.
module id_regfile
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];

    logic [1:0][REG_AW-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;

    assign rd_addr = {rb_addr, ra_addr};
    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs_reg[wa] <= wd;
        end
    end

    // R0 check comes first so a writeback aimed at R0 is never bypassed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] = (rd_addr[gi] == '0)               ? '0 :
                                 (we && (wa == rd_addr[gi]))        ? wd :
                                                                      regs_reg[rd_addr[gi]];
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: decodes the IF/ID slot, resolves branches/jumps,
// detects hazards, holds the HALT state and loads the ID/EX register.
module decode_stage
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] inst_in,
    input  logic              inst_valid_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              flush,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              halted,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [3:0]        ex_op,
    output logic [3:0]        ex_func,
    output logic [3:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a_data,
    output logic [DATA_W-1:0] ex_b_data,
    output logic [DATA_W-1:0] ex_imm
);

    state_t state_reg;
    state_t state_next;
    idex_t  ex_reg;
    idex_t  ex_next;

    logic [DATA_W-1:0] inst_eff;
    logic [3:0]        f_op;
    logic [3:0]        f_a;
    logic [3:0]        f_b;
    logic [3:0]        f_c;

    logic is_alu, is_lw, is_sw, is_beq, is_bne, is_jmp, is_halt;
    logic is_branch, uses_a, uses_b, issues;
    logic load_use, branch_dep, hazard;
    logic operands_equal, redirect;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] br_offset;
    logic [DATA_W-1:0] redirect_addr;

    // An empty IF/ID slot is decoded as a NOP so it can never hazard or redirect.
    assign inst_eff = inst_valid_in ? inst_in : NOP_INST;
    assign f_op     = inst_eff[OP_MSB:OP_LSB];
    assign f_a      = inst_eff[FA_MSB:FA_LSB];
    assign f_b      = inst_eff[FB_MSB:FB_LSB];
    assign f_c      = inst_eff[FC_MSB:FC_LSB];

    always_comb begin
        is_alu    = (f_op == OP_ALU);
        is_lw     = (f_op == OP_LW);
        is_sw     = (f_op == OP_SW);
        is_beq    = (f_op == OP_BEQ);
        is_bne    = (f_op == OP_BNE);
        is_jmp    = (f_op == OP_JMP);
        is_halt   = (f_op == OP_HALT);
        is_branch = is_beq || is_bne;
        uses_a    = is_alu || is_sw || is_branch;
        uses_b    = is_alu || is_lw || is_sw || is_branch;
        issues    = is_alu || is_lw || is_sw;
    end

    id_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (f_a),
        .ra_data (rd_a),
        .rb_addr (f_b),
        .rb_data (rd_b),
        .we      (wb_en),
        .wa      (wb_addr),
        .wd      (wb_data)
    );

    assign load_use = ex_reg.valid && ex_reg.mem_read &&
                      ((uses_a && (ex_reg.rd == f_a)) || (uses_b && (ex_reg.rd == f_b)));

    // Branches compare in ID, so any in-flight ALU/LW result they read must land first.
    assign branch_dep = is_branch && ex_reg.valid && ex_reg.reg_write && (ex_reg.rd != '0) &&
                        ((ex_reg.rd == f_a) || (ex_reg.rd == f_b));

    assign hazard = inst_valid_in && (load_use || branch_dep);

    assign operands_equal = (rd_a == rd_b);
    assign redirect       = is_jmp || (is_beq && operands_equal) || (is_bne && !operands_equal);
    assign br_offset      = is_jmp ? sext12(inst_eff[JOFF_MSB:0]) : sext4(f_c);
    assign redirect_addr  = pc_in + (br_offset << 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= RUN;
            ex_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ex_reg    <= ex_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        ex_next       = '0;
        if (rst) begin
            case (state_reg)
                RUN: begin
                    stall = hazard;
                    if (!hazard) begin
                        if (redirect) begin
                            branch_taken  = 1'b1;
                            flush         = 1'b1;
                            branch_target = redirect_addr;
                        end
                        if (is_halt) begin
                            state_next = HALTED;
                        end
                        if (issues) begin
                            ex_next.valid     = 1'b1;
                            ex_next.mem_read  = is_lw;
                            ex_next.mem_write = is_sw;
                            ex_next.reg_write = is_alu || is_lw;
                            ex_next.op        = f_op;
                            ex_next.func      = f_c;
                            ex_next.rd        = (is_alu || is_lw) ? f_a : 4'h0;
                            ex_next.a_data    = rd_a;
                            ex_next.b_data    = rd_b;
                            ex_next.imm       = sext4(f_c);
                        end
                    end
                end
                HALTED: begin
                    stall = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign halted       = (state_reg == HALTED);
    assign ex_valid     = ex_reg.valid;
    assign ex_mem_read  = ex_reg.mem_read;
    assign ex_mem_write = ex_reg.mem_write;
    assign ex_reg_write = ex_reg.reg_write;
    assign ex_op        = ex_reg.op;
    assign ex_func      = ex_reg.func;
    assign ex_rd        = ex_reg.rd;
    assign ex_a_data    = ex_reg.a_data;
    assign ex_b_data    = ex_reg.b_data;
    assign ex_imm       = ex_reg.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural model of the decode rules.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in;
    logic [15:0] inst_in;
    logic        inst_valid_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall, flush, branch_taken, halted;
    logic [15:0] branch_target;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [3:0]  ex_op, ex_func, ex_rd;
    logic [15:0] ex_a_data, ex_b_data, ex_imm;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state for the randomized run.
    logic [15:0] m_regs [16];
    logic        m_ex_valid;
    logic        m_ex_mem_read;
    logic        m_ex_reg_write;
    logic [3:0]  m_ex_rd;
    logic [3:0]  other_ops [9] = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD, 4'hE};

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .inst_in       (inst_in),
        .inst_valid_in (inst_valid_in),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_op         (ex_op),
        .ex_func       (ex_func),
        .ex_rd         (ex_rd),
        .ex_a_data     (ex_a_data),
        .ex_b_data     (ex_b_data),
        .ex_imm        (ex_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [15:0] pc, input logic [15:0] inst, input logic valid,
                         input logic wen, input logic [3:0] waddr, input logic [15:0] wdata);
        pc_in         = pc;
        inst_in       = inst;
        inst_valid_in = valid;
        wb_en         = wen;
        wb_addr       = waddr;
        wb_data       = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] r);
        if (r == 4'd0) return 16'h0000;
        if (wb_en && (wb_addr == r)) return wb_data;
        return m_regs[r];
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(16'h0010, 16'h4000, 1'b1, 1'b0, 4'h0, 16'h0);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken, branch_target} !== 19'h0) begin
            failures++;
            $display("FAIL reset_comb got=%h required=0", {stall, flush, branch_taken, branch_target});
        end
        checks++;
        if ({halted, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd,
             ex_a_data, ex_b_data, ex_imm} !== 65'h0) begin
            failures++;
            $display("FAIL reset_regs halted=%b ex_valid=%b ex_a=%h required=all zero",
                     halted, ex_valid, ex_a_data);
        end
    endtask

    task automatic test_alu();
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b1, 4'h1, 16'd5);
        tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b1, 4'h2, 16'd3);
        tick();
        drive(16'h0002, 16'h0120, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL alu_no_stall got=%b required=0", stall);
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd} !== 16'h9001) begin
            failures++;
            $display("FAIL alu_ctrl got=%h required=9001",
                     {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd});
        end
        checks++;
        if ({ex_a_data, ex_b_data, ex_imm} !== {16'd5, 16'd3, 16'd0}) begin
            failures++;
            $display("FAIL alu_data got=%h/%h/%h required=0005/0003/0000", ex_a_data, ex_b_data, ex_imm);
        end
        drive(16'h0004, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_bubble got=%b required=0", ex_valid);
        end
    endtask

    task automatic test_load_use();
        drive(16'h0004, 16'h8320, 1'b1, 1'b0, 4'h0, 16'h0);
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd, ex_b_data} !==
            {4'b1101, 4'h8, 4'h0, 4'h3, 16'd3}) begin
            failures++;
            $display("FAIL lw_issue got=%b%b%b%b op=%h rd=%h b=%h required=1101 op=8 rd=3 b=0003",
                     ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_rd, ex_b_data);
        end
        drive(16'h0006, 16'h0340, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken} !== 3'b100) begin
            failures++;
            $display("FAIL load_use_stall got=%b required=100", {stall, flush, branch_taken});
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_rd} !== 12'h0) begin
            failures++;
            $display("FAIL load_use_bubble got=%h required=000",
                     {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_rd});
        end
        @(negedge clk);
        checks++;
        if ({stall, flush} !== 2'b00) begin
            failures++;
            $display("FAIL load_use_release got=%b required=00", {stall, flush});
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write, ex_op, ex_rd} !== {3'b101, 4'h0, 4'h3}) begin
            failures++;
            $display("FAIL load_use_alu got=%b%b%b op=%h rd=%h required=101 op=0 rd=3",
                     ex_valid, ex_mem_read, ex_reg_write, ex_op, ex_rd);
        end
        drive(16'h0008, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
    endtask

    task automatic test_branch();
        drive(16'h0000, 16'h0000, 1'b0, 1'b1, 4'h1, 16'd3);
        tick();
        drive(16'h0010, 16'h412E, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken, branch_target} !== {3'b011, 16'h000C}) begin
            failures++;
            $display("FAIL beq_taken got=%b%b%b tgt=%h required=011 tgt=000c",
                     stall, flush, branch_taken, branch_target);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL beq_bubble got=%b required=0", ex_valid);
        end
        drive(16'h0012, 16'h0000, 1'b0, 1'b1, 4'h1, 16'd9);
        @(negedge clk);
        checks++;
        if ({flush, branch_taken, branch_target} !== 18'h0) begin
            failures++;
            $display("FAIL beq_one_cycle got=%b%b tgt=%h required=00 tgt=0000",
                     flush, branch_taken, branch_target);
        end
        tick();
        drive(16'h0010, 16'h412E, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken, branch_target} !== 19'h0) begin
            failures++;
            $display("FAIL beq_not_taken got=%b%b%b tgt=%h required=000 tgt=0000",
                     stall, flush, branch_taken, branch_target);
        end
        tick();
        drive(16'h0010, 16'h512E, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({flush, branch_taken, branch_target} !== {2'b11, 16'h000C}) begin
            failures++;
            $display("FAIL bne_taken got=%b%b tgt=%h required=11 tgt=000c", flush, branch_taken, branch_target);
        end
        tick();
        drive(16'h0002, 16'hCFFE, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({branch_taken, branch_target} !== {1'b1, 16'hFFFE}) begin
            failures++;
            $display("FAIL jmp_wrap_down got=%b tgt=%h required=1 tgt=fffe", branch_taken, branch_target);
        end
        tick();
        drive(16'hFFFE, 16'hC001, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({branch_taken, branch_target} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL jmp_wrap_up got=%b tgt=%h required=1 tgt=0000", branch_taken, branch_target);
        end
        tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
    endtask

    task automatic test_bne_hazard();
        drive(16'h003E, 16'h0120, 1'b1, 1'b0, 4'h0, 16'h0);
        tick();
        drive(16'h0040, 16'h5120, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken} !== 3'b100) begin
            failures++;
            $display("FAIL branch_dep_stall got=%b required=100", {stall, flush, branch_taken});
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_dep_bubble got=%b required=0", ex_valid);
        end
        // Stored R1 is 9 (would take); the bypassed writeback of 3 equals R2, so no redirect.
        drive(16'h0040, 16'h5120, 1'b1, 1'b1, 4'h1, 16'd3);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken, branch_target} !== 19'h0) begin
            failures++;
            $display("FAIL bne_bypass got=%b%b%b tgt=%h required=000 tgt=0000",
                     stall, flush, branch_taken, branch_target);
        end
        tick();
        drive(16'h0042, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
    endtask

    task automatic test_r0();
        drive(16'h0050, 16'h0000, 1'b1, 1'b1, 4'h0, 16'hFFFF);
        tick();
        checks++;
        if ({ex_valid, ex_a_data, ex_b_data} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL r0_bypass got=%b a=%h b=%h required=1 a=0000 b=0000", ex_valid, ex_a_data, ex_b_data);
        end
        drive(16'h0052, 16'h0010, 1'b1, 1'b0, 4'h0, 16'h0);
        tick();
        checks++;
        if ({ex_a_data, ex_b_data} !== {16'h0000, 16'h0003}) begin
            failures++;
            $display("FAIL r0_read got=a=%h b=%h required=a=0000 b=0003", ex_a_data, ex_b_data);
        end
        drive(16'h0054, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
    endtask

    task automatic test_random();
        logic [15:0] cur_pc, cur_inst, va, vb, exp_tgt;
        logic [3:0]  op, ia, ib, ic;
        logic        cur_valid, prev_stall, prev_flush;
        logic        uses_a, uses_b, is_br, hz, go, tk, iss;
        logic [63:0] exp_ex, got_ex;
        int          off;
        rst = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_ex_valid = 0; m_ex_mem_read = 0; m_ex_reg_write = 0; m_ex_rd = 4'h0;
        prev_stall = 0; prev_flush = 0;
        cur_pc = 16'h0; cur_inst = 16'h0; cur_valid = 0;
        for (int n = 0; n < 300; n++) begin
            if (!prev_stall) begin
                ia = 4'($urandom_range(0, 3));
                ib = 4'($urandom_range(0, 3));
                ic = 4'($urandom);
                case ($urandom_range(0, 7))
                    0, 1:    op = 4'h0;
                    2:       op = 4'h8;
                    3:       op = 4'hB;
                    4:       op = 4'h4;
                    5:       op = 4'h5;
                    6:       op = 4'hC;
                    default: op = other_ops[$urandom_range(0, 8)];
                endcase
                cur_inst = {op, ia, ib, ic};
                if (op == 4'hC) cur_inst[11:0] = 12'($urandom);
                cur_pc    = 16'($urandom);
                cur_valid = !prev_flush && ($urandom_range(0, 7) != 0);
            end
            drive(cur_pc, cur_inst, cur_valid, 1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
            @(negedge clk);
            op = cur_inst[15:12]; ia = cur_inst[11:8]; ib = cur_inst[7:4]; ic = cur_inst[3:0];
            va = model_read(ia);
            vb = model_read(ib);
            uses_a = cur_valid && (op inside {4'h0, 4'hB, 4'h4, 4'h5});
            uses_b = cur_valid && (op inside {4'h0, 4'h8, 4'hB, 4'h4, 4'h5});
            is_br  = cur_valid && (op inside {4'h4, 4'h5});
            hz = (m_ex_valid && m_ex_mem_read && ((uses_a && m_ex_rd == ia) || (uses_b && m_ex_rd == ib))) ||
                 (is_br && m_ex_valid && m_ex_reg_write && m_ex_rd != 0 && (m_ex_rd == ia || m_ex_rd == ib));
            go  = cur_valid && !hz;
            tk  = go && ((op == 4'h4 && va == vb) || (op == 4'h5 && va != vb) || op == 4'hC);
            iss = go && (op inside {4'h0, 4'h8, 4'hB});
            off = (op == 4'hC) ? int'($signed(cur_inst[11:0])) : int'($signed(ic));
            exp_tgt = tk ? 16'(int'(cur_pc) + 2 * off) : 16'h0;
            checks++;
            if ({stall, flush, branch_taken, branch_target} !== {hz, tk, tk, exp_tgt}) begin
                failures++;
                $display("FAIL rand_comb n=%0d inst=%h got=%b%b%b tgt=%h required=%b%b%b tgt=%h",
                         n, cur_inst, stall, flush, branch_taken, branch_target, hz, tk, tk, exp_tgt);
            end
            exp_ex = iss ? {1'b1, op == 4'h8, op == 4'hB, op == 4'h0 || op == 4'h8, op, ic,
                            (op == 4'h0 || op == 4'h8) ? ia : 4'h0, va, vb, 16'(int'($signed(ic)))}
                         : 64'h0;
            @(posedge clk);
            if (wb_en && wb_addr != 4'h0) m_regs[wb_addr] = wb_data;
            m_ex_valid     = iss;
            m_ex_mem_read  = iss && op == 4'h8;
            m_ex_reg_write = iss && (op == 4'h0 || op == 4'h8);
            m_ex_rd        = exp_ex[51:48];
            #1;
            got_ex = {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd,
                      ex_a_data, ex_b_data, ex_imm};
            checks++;
            if ({halted, got_ex} !== {1'b0, exp_ex}) begin
                failures++;
                $display("FAIL rand_idex n=%0d inst=%h got=%b/%h required=0/%h", n, cur_inst, halted, got_ex, exp_ex);
            end
            $display("txn %0d pc=%h inst=%h v=%b stall=%b taken=%b ex=%h", n, cur_pc, cur_inst,
                     cur_valid, hz, tk, got_ex);
            prev_stall = hz;
            prev_flush = tk;
        end
        drive(16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        tick();
    endtask

    task automatic test_halt();
        drive(16'h0060, 16'hF000, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken} !== 3'b000) begin
            failures++;
            $display("FAIL halt_enter_comb got=%b required=000", {stall, flush, branch_taken});
        end
        tick();
        checks++;
        if ({halted, ex_valid} !== 2'b10) begin
            failures++;
            $display("FAIL halt_enter got=%b required=10", {halted, ex_valid});
        end
        for (int k = 0; k < 12; k++) begin
            drive(16'($urandom), (k % 2 == 0) ? 16'h4000 : 16'h0120, 1'b1, 1'b0, 4'h0, 16'h0);
            @(negedge clk);
            checks++;
            if ({halted, stall, flush, branch_taken, branch_target} !== {4'b1100, 16'h0}) begin
                failures++;
                $display("FAIL halt_hold k=%0d got=%b%b%b%b tgt=%h required=1100 tgt=0000",
                         k, halted, stall, flush, branch_taken, branch_target);
            end
            tick();
            checks++;
            if ({ex_valid, ex_reg_write, ex_rd} !== 6'h0) begin
                failures++;
                $display("FAIL halt_bubble k=%0d got=%b%b rd=%h required=00 rd=0", k, ex_valid, ex_reg_write, ex_rd);
            end
        end
        rst = 1'b0;
        drive(16'h0070, 16'h4000, 1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        checks++;
        if ({stall, flush, branch_taken, branch_target} !== 19'h0) begin
            failures++;
            $display("FAIL halt_reset_comb got=%h required=0", {stall, flush, branch_taken, branch_target});
        end
        tick();
        rst = 1'b1;
        drive(16'h0072, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0);
        checks++;
        if ({halted, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_op, ex_func, ex_rd,
             ex_a_data, ex_b_data, ex_imm} !== 65'h0) begin
            failures++;
            $display("FAIL halt_reset_clear halted=%b ex_valid=%b required=0 0", halted, ex_valid);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL halt_exit_stall got=%b required=0", stall);
        end
        drive(16'h0074, 16'h0120, 1'b1, 1'b0, 4'h0, 16'h0);
        tick();
        checks++;
        if ({ex_valid, ex_a_data, ex_b_data} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL regs_cleared got=%b a=%h b=%h required=1 a=0000 b=0000", ex_valid, ex_a_data, ex_b_data);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        test_reset();
        test_alu();
        test_load_use();
        test_branch();
        test_bne_hazard();
        test_r0();
        test_random();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
